// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, widths and frame configuration.
package uart_pkg;

   localparam int unsigned CKDIV_W        = 24;
   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   // Per-frame format, captured when a byte is fetched
   typedef struct packed {
      logic data9b;
      logic stop2b;
   } uart_frame_cfg_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end is high while the count reads zero.
module uart_baud_cnt #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] div,
   output logic         bit_end
);

   logic [W-1:0] r_cnt;

   // Reload at each bit start, otherwise count down and hold at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= div;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and serialises
// start / 8 data (LSB first) / optional even parity / 1-2 stop bits.
module uart_tx_ctrl #(
   parameter int unsigned CKDIV_W = uart_pkg::CKDIV_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_n,
   input  logic [CKDIV_W-1:0] ckdiv,
   input  logic               data9b,
   input  logic               stop2b,
   input  logic               tf_empty,
   input  logic [7:0]         tf_rbyte,
   output logic               tf_read,
   output logic               uart_txd,
   output logic               txbusy
);

   import uart_pkg::*;

   uart_tx_state_t                r_state;
   uart_tx_state_t                w_state_nxt;
   uart_frame_cfg_t               r_cfg;
   logic [UART_DATA_BITS-1:0]     r_shift;
   logic [UART_IDX_W-1:0]         r_bit_idx;
   logic                          r_stop_idx;
   logic                          r_parity;
   logic                          r_txd;
   logic                          r_busy;
   logic                          r_read;

   logic                          w_bit_end;
   logic                          w_load;
   logic                          w_fetch;
   logic                          w_shift_en;
   logic                          w_stop_adv;
   logic                          w_txd_nxt;
   logic                          w_busy_nxt;
   logic                          w_read_nxt;

   uart_baud_cnt #(
      .W (CKDIV_W)
   ) u_baud_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_load),
      .div     (ckdiv),
      .bit_end (w_bit_end)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and sequencing strobes; soft clear overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_fetch     = 1'b0;
      w_shift_en  = 1'b0;
      w_stop_adv  = 1'b0;
      if (!clr_n) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (!tf_empty) begin
                  w_fetch     = 1'b1;
                  w_load      = 1'b1;
                  w_state_nxt = START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  w_load      = 1'b1;
                  w_state_nxt = DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  w_load = 1'b1;
                  if (r_bit_idx == UART_IDX_W'(UART_DATA_BITS - 1)) begin
                     w_state_nxt = r_cfg.data9b ? PARITY : STOP;
                  end else begin
                     w_shift_en = 1'b1;
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  w_load      = 1'b1;
                  w_state_nxt = STOP;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (r_cfg.stop2b && !r_stop_idx) begin
                     w_stop_adv = 1'b1;
                     w_load     = 1'b1;
                  end else if (!tf_empty) begin
                     w_fetch     = 1'b1;
                     w_load      = 1'b1;
                     w_state_nxt = START;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Next output values, derived from the state being entered
   always_comb begin
      w_read_nxt = w_fetch;
      w_busy_nxt = (w_state_nxt != IDLE);
      w_txd_nxt  = 1'b1;
      case (w_state_nxt)
         IDLE:    w_txd_nxt = 1'b1;
         START:   w_txd_nxt = 1'b0;
         DATA:    w_txd_nxt = w_shift_en ? r_shift[1] : r_shift[0];
         PARITY:  w_txd_nxt = r_parity;
         STOP:    w_txd_nxt = 1'b1;
         default: w_txd_nxt = 1'b1;
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txd  <= 1'b1;
         r_busy <= 1'b0;
         r_read <= 1'b0;
      end else begin
         r_txd  <= w_txd_nxt;
         r_busy <= w_busy_nxt;
         r_read <= w_read_nxt;
      end
   end

   // Frame datapath: byte/format capture on fetch, shift per data bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_parity   <= 1'b0;
         r_cfg      <= '0;
      end else if (w_fetch) begin
         r_shift    <= tf_rbyte;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_parity   <= ^tf_rbyte;
         r_cfg      <= '{data9b: data9b, stop2b: stop2b};
      end else begin
         if (w_shift_en) begin
            r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
            r_bit_idx <= UART_IDX_W'(r_bit_idx + 1'b1);
         end
         if (w_stop_adv) begin
            r_stop_idx <= 1'b1;
         end
      end
   end

   assign tf_read  = r_read;
   assign uart_txd = r_txd;
   assign txbusy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of single frames plus
// hand-written back-to-back, config-change, soft-clear and reset sequences.
module tb_uart_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_n;
   logic [23:0] ckdiv;
   logic        data9b;
   logic        stop2b;
   logic        tf_empty;
   logic [7:0]  tf_rbyte;
   logic        tf_read;
   logic        uart_txd;
   logic        txbusy;

   int n_chk  = 0;
   int n_pass = 0;

   // Small FIFO model: bench pushes, DUT pops via tf_read
   logic [7:0] fifo_mem [0:15];
   logic [3:0] head = 4'd0;
   logic [3:0] tail = 4'd0;
   int         pop_cnt = 0;

   assign tf_empty = (head == tail);
   assign tf_rbyte = fifo_mem[head];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tf_read && (head != tail)) begin
         head    <= head + 4'd1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   uart_tx_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_n    (clr_n),
      .ckdiv    (ckdiv),
      .data9b   (data9b),
      .stop2b   (stop2b),
      .tf_empty (tf_empty),
      .tf_rbyte (tf_rbyte),
      .tf_read  (tf_read),
      .uart_txd (uart_txd),
      .txbusy   (txbusy)
   );

   typedef struct {
      string       name;
      logic [23:0] div;
      logic        d9;
      logic        s2;
      logic [7:0]  data;
      logic [11:0] bits;   // line level per bit slot, slot 0 in bit 0
      int          nbits;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[tail] = b;
      tail = tail + 4'd1;
   endtask

   // Wait (bounded) for the pop strobe, sampled on falling edges
   task automatic wait_read(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tf_read) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check({name, "_timeout"}, 32'(tf_read), 32'd1);
   endtask

   // Check one whole frame cycle by cycle, then the line state just after it
   task automatic run_frame(input string name, input logic [11:0] bits, input int nbits,
                            input int d, input bit idle_after);
      bit ok;
      int bad;
      int len;
      wait_read(name, ok);
      if (!ok) return;
      bad = 0;
      len = nbits * (d + 1);
      for (int c = 0; c < len; c++) begin
         if (c > 0) @(negedge clk);
         if (uart_txd !== bits[c / (d + 1)]) bad++;
         if (txbusy !== 1'b1) bad++;
         if (tf_read !== (c == 0)) bad++;
      end
      check({name, "_frame"}, 32'(bad), 32'd0);
      @(negedge clk);
      if (idle_after) check({name, "_idle"}, {30'd0, txbusy, uart_txd}, 32'b01);
   endtask

   initial begin
      bit          ok;
      int          base;
      int          gap;
      int          cnt;
      int          rd_cnt;
      int          rd_pos;
      int          busy_cnt;
      logic [19:0] seq;

      vecs[0] = '{"v55_8n1",   24'd3, 1'b0, 1'b0, 8'h55, 12'h2AA, 10};
      vecs[1] = '{"v07_9b2s",  24'd1, 1'b1, 1'b1, 8'h07, 12'hE0E, 12};
      vecs[2] = '{"vA3_div0",  24'd0, 1'b0, 1'b0, 8'hA3, 12'h346, 10};
      vecs[3] = '{"v00_9b",    24'd2, 1'b1, 1'b0, 8'h00, 12'h400, 11};
      vecs[4] = '{"vFF_2s",    24'd0, 1'b0, 1'b1, 8'hFF, 12'h7FE, 11};
      vecs[5] = '{"v80_9b",    24'd4, 1'b1, 1'b0, 8'h80, 12'h700, 11};

      rst_n  = 1'b0;
      clr_n  = 1'b1;
      ckdiv  = 24'd3;
      data9b = 1'b0;
      stop2b = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_txd",  32'(uart_txd), 32'd1);
      check("rst_busy", 32'(txbusy),   32'd0);
      check("rst_read", 32'(tf_read),  32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frames from the table
      for (int i = 0; i < 6; i++) begin
         ckdiv  = vecs[i].div;
         data9b = vecs[i].d9;
         stop2b = vecs[i].s2;
         push(vecs[i].data);
         run_frame(vecs[i].name, vecs[i].bits, vecs[i].nbits, int'(vecs[i].div), 1'b1);
         @(negedge clk);
      end

      // Back-to-back frames with no idle gap
      ckdiv = 24'd0; data9b = 1'b0; stop2b = 1'b0;
      push(8'hA3);
      push(8'h0F);
      wait_read("b2b", ok);
      if (ok) begin
         rd_cnt = 0; rd_pos = -1; busy_cnt = 0; seq = '0;
         for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            seq[c] = uart_txd;
            if (txbusy) busy_cnt++;
            if (tf_read) begin
               rd_cnt++;
               if (c > 0) rd_pos = c;
            end
         end
         check("b2b_seq",   32'(seq),      {12'd0, 10'h21E, 10'h346});
         check("b2b_busy",  32'(busy_cnt), 32'd20);
         check("b2b_reads", 32'(rd_cnt),   32'd2);
         check("b2b_gap",   32'(rd_pos),   32'd10);
         @(negedge clk);
         check("b2b_idle", {30'd0, txbusy, uart_txd}, 32'b01);
      end
      @(negedge clk);

      // stop2b changed mid-frame only affects the following frame
      ckdiv = 24'd1; data9b = 1'b0; stop2b = 1'b0;
      push(8'h3C);
      push(8'h3C);
      wait_read("cfg", ok);
      if (ok) begin
         repeat (5) @(negedge clk);
         stop2b = 1'b1;
         gap = 5;
         while (gap < 80) begin
            @(negedge clk);
            gap++;
            if (tf_read) break;
         end
         check("cfg_gap", 32'(gap), 32'd20);
         cnt = 0;
         while (txbusy && cnt < 60) begin
            cnt++;
            @(negedge clk);
         end
         check("cfg_len2", 32'(cnt), 32'd22);
      end
      stop2b = 1'b0;
      @(negedge clk);

      // Soft clear during data bit 3 of 0xFF with a second byte queued
      ckdiv = 24'd1;
      base  = pop_cnt;
      push(8'hFF);
      push(8'h11);
      wait_read("clr", ok);
      if (ok) begin
         repeat (8) @(negedge clk);
         check("clr_bit3", 32'(uart_txd), 32'd1);
         clr_n = 1'b0;
         @(negedge clk);
         check("clr_out",  {29'd0, uart_txd, txbusy, tf_read}, 32'b100);
         check("clr_pops", 32'(pop_cnt - base), 32'd1);
         clr_n = 1'b1;
         run_frame("clr_next", 12'h222, 10, 1, 1'b1);
         check("clr_pops2", 32'(pop_cnt - base), 32'd2);
      end

      // No pop while clr_n is held low
      clr_n = 1'b0;
      base  = pop_cnt;
      push(8'h55);
      repeat (4) @(negedge clk);
      check("clrhold_pops", 32'(pop_cnt - base), 32'd0);
      check("clrhold_busy", 32'(txbusy), 32'd0);
      clr_n = 1'b1;
      run_frame("clrhold_next", 12'h2AA, 10, 1, 1'b1);

      // Asynchronous reset while the parity bit is on the line
      ckdiv = 24'd1; data9b = 1'b1; stop2b = 1'b1;
      push(8'h07);
      wait_read("arst", ok);
      if (ok) begin
         repeat (18) @(negedge clk);
         check("arst_par", {30'd0, txbusy, uart_txd}, 32'b11);
         #2 rst_n = 1'b0;
         #1;
         check("arst_out", {29'd0, uart_txd, txbusy, tf_read}, 32'b100);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         check("arst_idle", {30'd0, txbusy, uart_txd}, 32'b01);
      end
      ckdiv = 24'd0; data9b = 1'b0; stop2b = 1'b0;
      push(8'hA3);
      run_frame("arst_next", 12'h346, 10, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit sequencer for the UART. It pops bytes from the 32-deep TX byte FIFO and serialises each one onto `uart_txd` as a frame: start bit, 8 data bits LSB-first, an optional even-parity 9th bit, then 1 or 2 stop bits. Bit timing comes from the register-block `ckdiv` field. The block sits between `u_tfifo` and the pad, and drives the `txbusy` status bit back to the register block.

## Interface
Parameters:
- `CKDIV_W`, default 24: width of the bit-period divider.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr_n`  in  1  synchronous soft clear, active-low, from the register block.
- `ckdiv`  in  CKDIV_W  bit period minus one, in clk cycles.
- `data9b`  in  1  1 = append even-parity bit after the data bits.
- `stop2b`  in  1  1 = two stop bits, 0 = one.
- `tf_empty`  in  1  TX FIFO empty.
- `tf_rbyte`  in  8  TX FIFO head byte; show-ahead, valid whenever `tf_empty`=0.
- `tf_read`  out  1  one-cycle pop strobe to the TX FIFO.
- `uart_txd`  out  1  serial output; idle high.
- `txbusy`  out  1  high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `txd`=1, `txbusy`=0.
  - When `tf_empty`=0 and `clr_n`=1: latch `tf_rbyte` into the shift register, pulse `tf_read` for one cycle, latch `data9b`/`stop2b`, then go to START.
- **START**: `txd`=0 for one bit period, then go to DATA.
- **DATA**
  - `txd` = shift register bit 0; shift right each bit period.
  - 3-bit index counts 0..7.
  - After bit 7: go to PARITY if latched `data9b`=1, else go to STOP.
- **PARITY**: `txd` = XOR of the 8 latched data bits (even parity). Go to STOP after one bit period.
- **STOP**
  - `txd`=1 for 1 or 2 bit periods (latched `stop2b`).
  - At the end of the final stop bit: if `tf_empty`=0, do the IDLE fetch actions and go directly to START (no idle gap); otherwise go to IDLE.
- **Bit period**: down-counter loaded with `ckdiv` at each bit start; the bit ends when the counter reads 0.
  - A bit lasts `ckdiv`+1 cycles; `ckdiv`=0 gives one cycle per bit.
  - `ckdiv` is sampled at each bit start.
  - `data9b`/`stop2b` are sampled only at frame fetch, so mid-frame changes affect the next frame only.
- **Frame length**: (10 + `data9b` + `stop2b`) × (`ckdiv`+1) cycles.
- **`clr_n`=0 (synchronous, any state)**: next cycle state=IDLE, `txd`=1, `txbusy`=0, `tf_read`=0. The partially sent byte is discarded. No pop is issued while `clr_n`=0.
- **`tf_empty` rising mid-frame**: no effect on the current frame.

## Timing
- Reset values: `uart_txd`=1, `txbusy`=0, `tf_read`=0, state=IDLE, counters=0.
- All outputs are registered.
- `tf_read` asserts exactly one cycle per frame, in the cycle the state leaves IDLE/STOP for START.
- `txd` falls in the same cycle `tf_read` is high, i.e. 1 cycle after `tf_empty`=0 is first sampled in IDLE.
- `txbusy` rises with the start bit and falls in the cycle `txd` would begin the idle period. It stays high continuously across back-to-back frames.
- Asserting `rst_n` mid-frame forces the reset values immediately (asynchronously).

## Structure
- Shared package `uart_pkg` holds:
  - state enum `uart_tx_state_t` (IDLE/START/DATA/PARITY/STOP);
  - `CKDIV_W`=24;
  - `UART_DATA_BITS`=8.
  The future RX sequencer reuses these.
- One sub-module, `uart_baud_cnt`:
  - loadable down-counter with inputs `load` and `div`, output `bit_end`;
  - shared with the RX side.
- Everything else (FSM, shift register, parity, stop count) lives in `uart_tx_ctrl`.

## Test plan
- **8N1 single byte**: `ckdiv`=3, FIFO holds 0x55.
  - `txd` = 0, 1,0,1,0,1,0,1,0, 1, each level held 4 cycles.
  - One `tf_read` pulse; `txbusy` high exactly 40 cycles.
- **Back-to-back frames**: `ckdiv`=0, FIFO holds 0xA3, 0x0F.
  - Two `tf_read` pulses exactly 10 cycles apart.
  - `txbusy` high 20 contiguous cycles; no idle-high gap between the stop bit and the second start bit.
- **9-bit + 2 stop bits**: `ckdiv`=1, `data9b`=1, `stop2b`=1, byte 0x07.
  - Data bits 1,1,1,0,0,0,0,0, parity bit 1, two stop bits.
  - Frame 24 cycles.
- **Config change mid-frame**: toggle `stop2b` 0→1 during DATA of the first byte. The first frame has 1 stop bit; the second frame has 2.
- **Soft clear mid-frame**: assert `clr_n`=0 for 1 cycle during data bit 3 of 0xFF, with 2 bytes queued.
  - Next cycle: `txd`=1 and `txbusy`=0.
  - Exactly one pop is observed before the clear; the next frame starts only after `clr_n` returns high.
- **Async reset mid-frame**: `rst_n` low during PARITY.
  - `txd`=1, `txbusy`=0, `tf_read`=0 immediately, without waiting for a clock edge.
  - After release, the FSM restarts cleanly from IDLE.
